// File: rtl/fpu_result_collector_if.sv
// Handshake bundle between issuer, fpnew and core for fpu_result_collector.
// Sticky flag signals exist only with FPU_RC_STICKY_FLAGS_EN.
interface fpu_result_collector_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 1
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic             fpu_in_valid_o;
    logic             fpu_in_ready_i;
    logic             fpu_out_valid_i;
    logic             fpu_out_ready_o;
    logic [WIDTH-1:0] fpu_result_i;
    logic [4:0]       fpu_status_i;
    logic [TAG_W-1:0] fpu_tag_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [WIDTH-1:0] rsp_result_o;
    logic [4:0]       rsp_status_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic             spurious_o;
`ifdef FPU_RC_STICKY_FLAGS_EN
    logic [4:0]       fflags_o;
    logic             fflags_clr_i;
`endif

    modport slave (
        input  req_valid_i, fpu_in_ready_i,
        input  fpu_out_valid_i, fpu_result_i,
        input  fpu_status_i, fpu_tag_i,
        input  rsp_ready_i,
`ifdef FPU_RC_STICKY_FLAGS_EN
        input  fflags_clr_i,
        output fflags_o,
`endif
        output req_ready_o, fpu_in_valid_o,
        output fpu_out_ready_o, rsp_valid_o,
        output rsp_result_o, rsp_status_o,
        output rsp_tag_o, spurious_o
    );

    modport master (
        output req_valid_i, fpu_in_ready_i,
        output fpu_out_valid_i, fpu_result_i,
        output fpu_status_i, fpu_tag_i,
        output rsp_ready_i,
`ifdef FPU_RC_STICKY_FLAGS_EN
        output fflags_clr_i,
        input  fflags_o,
`endif
        input  req_ready_o, fpu_in_valid_o,
        input  fpu_out_ready_o, rsp_valid_o,
        input  rsp_result_o, rsp_status_o,
        input  rsp_tag_o, spurious_o
    );
endinterface

// File: rtl/fpu_result_collector.sv
// Credit-gated in-order result FIFO behind fpnew.
// Optional sticky fflags register: define FPU_RC_STICKY_FLAGS_EN.
module fpu_result_collector #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int TAG_W = 1
) (
    input logic clk_i,
    input logic rst_ni,
    input logic flush_i,
    fpu_result_collector_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = WIDTH + 5 + TAG_W;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t FULL = cnt_t'(DEPTH);

    cnt_t          reserved_q;
    cnt_t          count_q;
    cnt_t          inflight;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] head;
    logic          credit;
    logic          issue;
    logic          push_hs;
    logic          push;
    logic          drop;
    logic          rsp_valid;
    logic          pop;
    logic          spurious_q;

    // Credit comes from the registered count only, so a pop never
    // frees a slot combinationally.
    assign credit   = reserved_q < FULL;
    assign issue    = bus.req_valid_i & credit & bus.fpu_in_ready_i;
    assign push_hs  = bus.fpu_out_valid_i & (count_q < FULL);
    assign inflight = reserved_q - count_q;
    assign push     = push_hs & (inflight != '0);
    assign drop     = push_hs & (inflight == '0);
    assign rsp_valid = count_q != '0;
    assign pop      = rsp_valid & bus.rsp_ready_i;
    assign head     = rsp_valid ? mem_q[rd_ptr_q] : '0;

    assign bus.req_ready_o     = bus.fpu_in_ready_i & credit;
    assign bus.fpu_in_valid_o  = bus.req_valid_i & credit;
    assign bus.fpu_out_ready_o = count_q < FULL;
    assign bus.rsp_valid_o     = rsp_valid;
    assign bus.rsp_result_o    = head[EW-1 -: WIDTH];
    assign bus.rsp_status_o    = head[TAG_W +: 5];
    assign bus.rsp_tag_o       = head[TAG_W-1:0];
    assign bus.spurious_o      = spurious_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reserved_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            spurious_q <= 1'b0;
        end else if (flush_i) begin
            reserved_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            spurious_q <= 1'b0;
        end else begin
            reserved_q <= reserved_q + cnt_t'(issue) - cnt_t'(pop);
            count_q    <= count_q + cnt_t'(push) - cnt_t'(pop);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            spurious_q <= drop;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= {bus.fpu_result_i,
                                bus.fpu_status_i,
                                bus.fpu_tag_i};
        end
    end

`ifdef FPU_RC_STICKY_FLAGS_EN
    logic [4:0] fflags_q;

    // A pop coinciding with a clear still deposits its status.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fflags_q <= '0;
        end else if (flush_i) begin
            fflags_q <= '0;
        end else if (pop) begin
            fflags_q <= (bus.fflags_clr_i ? 5'b0 : fflags_q)
                      | head[TAG_W +: 5];
        end else if (bus.fflags_clr_i) begin
            fflags_q <= '0;
        end
    end

    assign bus.fflags_o = fflags_q;
`endif
endmodule

// File: tb/tb_fpu_result_collector.sv
// Self-checking bench for fpu_result_collector (DEPTH=4, WIDTH=16).
// Directed vector table, hand sequences and a queue-based random model.
module tb_fpu_result_collector;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    logic flush;
    int   tests;
    int   fails;

    fpu_result_collector_if #(.WIDTH(16), .TAG_W(1)) bus();

    fpu_result_collector #(
        .WIDTH(16),
        .DEPTH(DEPTH),
        .TAG_W(1)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .flush_i(flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv, ir, ov;
        logic [15:0] res;
        logic [4:0]  st;
        logic        tg, rr, fl;
        logic        e_rq, e_iv, e_or, e_vv;
        logic [15:0] e_res;
        logic [4:0]  e_st;
        logic        e_tg, e_sp;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [4:0]  st;
        logic        tg;
    } ent_t;

    function automatic vec_t mk(
        logic rv, logic ir, logic ov, logic [15:0] res,
        logic [4:0] st, logic tg, logic rr, logic fl,
        logic e_rq, logic e_iv, logic e_or, logic e_vv,
        logic [15:0] e_res, logic [4:0] e_st,
        logic e_tg, logic e_sp);
        vec_t v;
        v.rv = rv; v.ir = ir; v.ov = ov; v.res = res;
        v.st = st; v.tg = tg; v.rr = rr; v.fl = fl;
        v.e_rq = e_rq; v.e_iv = e_iv; v.e_or = e_or;
        v.e_vv = e_vv; v.e_res = e_res; v.e_st = e_st;
        v.e_tg = e_tg; v.e_sp = e_sp;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic drive(logic rv, logic ir, logic ov,
                         logic [15:0] res, logic [4:0] st,
                         logic tg, logic rr, logic fl,
                         logic clr);
        bus.req_valid_i     = rv;
        bus.fpu_in_ready_i  = ir;
        bus.fpu_out_valid_i = ov;
        bus.fpu_result_i    = res;
        bus.fpu_status_i    = st;
        bus.fpu_tag_i       = tg;
        bus.rsp_ready_i     = rr;
        flush               = fl;
`ifdef FPU_RC_STICKY_FLAGS_EN
        bus.fflags_clr_i    = clr;
`else
        if (clr) flush = fl;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vt[25];
    ent_t q[$];
    int   reserved;
    bit   sp_m;
    logic [4:0] ff_m;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        vt[0]  = mk(1,1,0,16'h0,0,0,0,0, 1,1,1,0,16'h0,0,0,0);
        vt[1]  = mk(0,1,1,16'h4000,0,1,0,0, 1,0,1,0,16'h0,0,0,0);
        vt[2]  = mk(0,1,0,16'h0,0,0,1,0, 1,0,1,1,16'h4000,0,1,0);
        vt[3]  = mk(0,1,0,16'h0,0,0,0,0, 1,0,1,0,16'h0,0,0,0);
        vt[4]  = mk(1,1,0,16'h0,0,0,0,0, 1,1,1,0,16'h0,0,0,0);
        vt[5]  = vt[4];
        vt[6]  = vt[4];
        vt[7]  = vt[4];
        vt[8]  = mk(1,1,0,16'h0,0,0,0,0, 0,0,1,0,16'h0,0,0,0);
        vt[9]  = mk(1,1,1,16'h3C00,1,0,0,0, 0,0,1,0,16'h0,0,0,0);
        vt[10] = mk(1,1,0,16'h0,0,0,1,0, 0,0,1,1,16'h3C00,1,0,0);
        vt[11] = mk(1,1,0,16'h0,0,0,0,0, 1,1,1,0,16'h0,0,0,0);
        vt[12] = mk(0,1,0,16'h0,0,0,0,0, 0,0,1,0,16'h0,0,0,0);
        vt[13] = mk(0,1,1,16'h3C00,2,0,1,0, 0,0,1,0,16'h0,0,0,0);
        vt[14] = mk(0,1,1,16'hBC00,4,1,1,0, 0,0,1,1,16'h3C00,2,0,0);
        vt[15] = mk(0,1,1,16'h7C00,8,0,1,0, 1,0,1,1,16'hBC00,4,1,0);
        vt[16] = mk(0,1,0,16'h0,0,0,1,0, 1,0,1,1,16'h7C00,8,0,0);
        vt[17] = mk(1,1,0,16'h0,0,0,0,0, 1,1,1,0,16'h0,0,0,0);
        vt[18] = vt[17];
        vt[19] = mk(0,1,1,16'h1234,16,1,0,0, 1,0,1,0,16'h0,0,0,0);
        vt[20] = mk(1,1,1,16'h5555,3,0,1,1, 1,1,1,1,16'h1234,16,1,0);
        vt[21] = mk(0,1,0,16'h0,0,0,0,0, 1,0,1,0,16'h0,0,0,0);
        vt[22] = mk(0,1,1,16'h0AAA,0,1,0,0, 1,0,1,0,16'h0,0,0,0);
        vt[23] = mk(0,1,0,16'h0,0,0,0,0, 1,0,1,0,16'h0,0,0,1);
        vt[24] = mk(0,1,0,16'h0,0,0,0,0, 1,0,1,0,16'h0,0,0,0);

        // Held in reset with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive($urandom, $urandom, $urandom, 16'($urandom),
                  5'($urandom), $urandom, $urandom, $urandom,
                  $urandom);
            #1;
            chk("rst_valid", bus.rsp_valid_o, 0);
            chk("rst_ready", bus.req_ready_o, bus.fpu_in_ready_i);
            chk("rst_spur", bus.spurious_o, 0);
            chk("rst_res", bus.rsp_result_o, 0);
`ifdef FPU_RC_STICKY_FLAGS_EN
            chk("rst_ff", bus.fflags_o, 0);
`endif
        end
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            drive(vt[i].rv, vt[i].ir, vt[i].ov, vt[i].res,
                  vt[i].st, vt[i].tg, vt[i].rr, vt[i].fl, 0);
            #1;
            chk($sformatf("v%0d_rq", i), bus.req_ready_o, vt[i].e_rq);
            chk($sformatf("v%0d_iv", i), bus.fpu_in_valid_o, vt[i].e_iv);
            chk($sformatf("v%0d_or", i), bus.fpu_out_ready_o, vt[i].e_or);
            chk($sformatf("v%0d_vv", i), bus.rsp_valid_o, vt[i].e_vv);
            chk($sformatf("v%0d_res", i), bus.rsp_result_o, vt[i].e_res);
            chk($sformatf("v%0d_st", i), bus.rsp_status_o, vt[i].e_st);
            chk($sformatf("v%0d_tg", i), bus.rsp_tag_o, vt[i].e_tg);
            chk($sformatf("v%0d_sp", i), bus.spurious_o, vt[i].e_sp);
        end

        // Async reset mid-operation.
        @(negedge clk); drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); drive(1, 1, 1, 16'hAAAA, 0, 1, 0, 0, 0);
        @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("mid_pre_vv", bus.rsp_valid_o, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_vv", bus.rsp_valid_o, 0);
        chk("mid_res", bus.rsp_result_o, 0);
        chk("mid_rq", bus.req_ready_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk("mid_credit", bus.req_ready_o, 1);
        end
        @(negedge clk); drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("mid_full", bus.fpu_in_valid_o, 0);

`ifdef FPU_RC_STICKY_FLAGS_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        end
        @(negedge clk); drive(0, 1, 1, 16'h1, 5'b00001, 0, 0, 0, 0);
        @(negedge clk); drive(0, 1, 1, 16'h2, 5'b10000, 0, 0, 0, 0);
        @(negedge clk); drive(0, 1, 1, 16'h3, 5'b00100, 0, 0, 0, 0);
        @(negedge clk); drive(0, 1, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk); drive(0, 1, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("ff_or", bus.fflags_o, 5'b10001);
        chk("ff_head", bus.rsp_status_o, 5'b00100);
        @(negedge clk); drive(0, 1, 0, 0, 0, 0, 1, 0, 1);
        @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("ff_clr_pop", bus.fflags_o, 5'b00100);
        @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("ff_clr", bus.fflags_o, 5'b00000);
`endif

        // Random traffic against a queue model.
        do_reset();
        q.delete();
        reserved = 0;
        sp_m = 0;
        ff_m = '0;
        for (int n = 0; n < 3000; n++) begin
            logic rv, ir, ov, rr, fl, clr, tg;
            logic [15:0] res;
            logic [4:0]  st;
            bit   credit, pop, iss, hs;
            int   infl;
            ent_t e;
            rv  = $urandom_range(0, 1);
            ir  = $urandom_range(0, 3) != 0;
            ov  = $urandom_range(0, 4) < 2;
            rr  = $urandom_range(0, 1);
            fl  = $urandom_range(0, 59) == 0;
            clr = $urandom_range(0, 7) == 0;
            res = 16'($urandom);
            st  = 5'($urandom);
            tg  = 1'($urandom);
            @(negedge clk);
            drive(rv, ir, ov, res, st, tg, rr, fl, clr);
            #1;
            credit = reserved < DEPTH;
            chk("r_rq", bus.req_ready_o, ir & credit);
            chk("r_iv", bus.fpu_in_valid_o, rv & credit);
            chk("r_or", bus.fpu_out_ready_o, q.size() < DEPTH);
            chk("r_vv", bus.rsp_valid_o, q.size() != 0);
            chk("r_res", bus.rsp_result_o,
                q.size() != 0 ? q[0].res : 16'h0);
            chk("r_st", bus.rsp_status_o,
                q.size() != 0 ? q[0].st : 5'h0);
            chk("r_tg", bus.rsp_tag_o,
                q.size() != 0 ? q[0].tg : 1'b0);
            chk("r_sp", bus.spurious_o, sp_m);
`ifdef FPU_RC_STICKY_FLAGS_EN
            chk("r_ff", bus.fflags_o, ff_m);
`endif
            if (fl) begin
                q.delete();
                reserved = 0;
                sp_m = 0;
                ff_m = '0;
            end else begin
                pop  = (q.size() != 0) && rr;
                iss  = rv && ir && credit;
                hs   = ov && (q.size() < DEPTH);
                infl = reserved - q.size();
                if (pop) begin
                    e = q.pop_front();
                    ff_m = (clr ? 5'b0 : ff_m) | e.st;
                end else if (clr) begin
                    ff_m = '0;
                end
                if (hs && infl > 0) begin
                    e.res = res; e.st = st; e.tg = tg;
                    q.push_back(e);
                end
                sp_m = hs && (infl == 0);
                reserved = reserved + int'(iss) - int'(pop);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
